// File: rtl/instr_fetch_pkg.sv
// Shared constants and the FIFO entry type for the instruction fetch stage.
package instr_fetch_pkg;
  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;
  localparam int          INSTR_W     = 32;
  localparam logic [31:0] PC_INC      = 32'd4;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_fetch_fifo.sv
// DEPTH-entry {pc,instr} FIFO with a flush that empties it in one edge.
module fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic         i_pop,
  input  fetch_entry_t i_entry,
  output logic         o_full,
  output logic         o_valid,
  output fetch_entry_t o_head
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_entry_t    r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;

  // Storage is not reset; the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != '0);
  assign o_full  = (r_count == FULL_CNT);
  assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: fetch PC drives the memory, returned words are queued.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [31:0]        o_imem_addr,
  input  logic [INSTR_W-1:0] i_imem_data,
  input  logic               i_redirect_valid,
  input  logic [31:0]        i_redirect_pc,
  output logic               o_out_valid,
  output logic [INSTR_W-1:0] o_out_instr,
  output logic [31:0]        o_out_pc,
  input  logic               i_out_ready
);
  logic [31:0]  r_fpc;
  logic         w_full, w_enq, w_deq;
  fetch_entry_t w_head, w_entry;
  logic         w_unused_pc_lsbs;

  assign w_unused_pc_lsbs = &{1'b0, i_redirect_pc[1:0]};

  // A redirect suppresses both sides of the queue for that cycle.
  assign w_deq   = o_out_valid && i_out_ready && !i_redirect_valid;
  assign w_enq   = !i_redirect_valid && (!w_full || w_deq);
  assign w_entry = '{pc: r_fpc, instr: i_imem_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_fpc <= {RESET_PC[31:2], 2'b00};
    else if (i_redirect_valid) r_fpc <= {i_redirect_pc[31:2], 2'b00};
    else if (w_enq)            r_fpc <= r_fpc + PC_INC;
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (i_redirect_valid),
    .i_push  (w_enq),
    .i_pop   (w_deq),
    .i_entry (w_entry),
    .o_full  (w_full),
    .o_valid (o_out_valid),
    .o_head  (w_head)
  );

  assign o_imem_addr = r_fpc;
  assign o_out_pc    = w_head.pc;
  assign o_out_instr = w_head.instr;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a small combinational instruction memory.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr, imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_pc;
  int          checks = 0;
  int          errors = 0;

  instr_fetch #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .o_imem_addr      (imem_addr),
    .i_imem_data      (imem_data),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_out_valid      (out_valid),
    .o_out_instr      (out_instr),
    .o_out_pc         (out_pc),
    .i_out_ready      (out_ready)
  );

  always #5 clk = ~clk;

  // Memory image: a few fixed words, FFFFFFFC unmapped, others addr^A5A50000.
  always_comb begin
    case (imem_addr)
      32'h0000_0000: imem_data = 32'h2011_0003;
      32'h0000_0020: imem_data = 32'h2013_000F;
      32'hFFFF_FFFC: imem_data = 32'h0000_0000;
      default:       imem_data = imem_addr ^ 32'hA5A5_0000;
    endcase
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", out_pc); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", out_instr); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
    step();
    out_ready = 1'b1;
    rst_n = 1'b1;
  endtask

  task automatic test_first_fetch();
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %0b exp 1", out_valid); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL first_pc got %h exp 0", out_pc); end
    checks++; if (out_instr !== 32'h2011_0003) begin errors++; $display("FAIL first_instr got %h exp 20110003", out_instr); end
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL first_addr got %h exp 4", imem_addr); end
    step();
    checks++; if (out_pc !== 32'h4 || out_instr !== 32'hA5A5_0004) begin
      errors++; $display("FAIL second_word got %h/%h exp 4/a5a50004", out_pc, out_instr); end
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      errors++; $display("FAIL fill_head got v=%0b pc=%h exp v=1 pc=0", out_valid, out_pc); end
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL fill_addr got %h exp 8", imem_addr); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'(i * 4)) begin
        errors++; $display("FAIL stream_pc[%0d] got v=%0b pc=%h exp %h", i, out_valid, out_pc, i * 4); end
      if (i == 2) begin
        checks++; if (out_instr !== 32'hA5A5_0008) begin
          errors++; $display("FAIL stream_instr got %h exp a5a50008", out_instr); end
      end
      step();
    end
    checks++; if (out_pc !== 32'h10) begin errors++; $display("FAIL stream_next got %h exp 10", out_pc); end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1; redirect_pc = 32'h23; out_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0) begin
      errors++; $display("FAIL redir_flush got v=%0b pc=%h exp 0/0", out_valid, out_pc); end
    checks++; if (imem_addr !== 32'h20) begin errors++; $display("FAIL redir_addr got %h exp 20", imem_addr); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h20 || out_instr !== 32'h2013_000F) begin
      errors++; $display("FAIL redir_word got v=%0b %h/%h exp 1 20/2013000f", out_valid, out_pc, out_instr); end
  endtask

  task automatic test_back_to_back();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_pc = 32'h41;
    step();
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h40) begin
      errors++; $display("FAIL b2b_flush got v=%0b addr=%h exp 0/40", out_valid, imem_addr); end
    step();
    checks++; if (out_pc !== 32'h40 || out_instr !== 32'hA5A5_0040) begin
      errors++; $display("FAIL b2b_word got %h/%h exp 40/a5a50040", out_pc, out_instr); end
  endtask

  task automatic test_wrap();
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got %h exp fffffffc", imem_addr); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC || out_instr !== 32'h0) begin
      errors++; $display("FAIL wrap_top got v=%0b %h/%h exp 1 fffffffc/0", out_valid, out_pc, out_instr); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_rollover got %h exp 0", imem_addr); end
    step();
    out_ready = 1'b1;
    step();
    checks++; if (out_pc !== 32'h0 || out_instr !== 32'h2011_0003) begin
      errors++; $display("FAIL wrap_next got %h/%h exp 0/20110003", out_pc, out_instr); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h80;
    step();
    redirect_valid = 1'b0;
    step(); step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h80 || imem_addr !== 32'h88) begin
      errors++; $display("FAIL areset_pre got v=%0b pc=%h addr=%h exp 1/80/88", out_valid, out_pc, imem_addr); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL areset_async got v=%0b pc=%h instr=%h addr=%h exp all 0",
                         out_valid, out_pc, out_instr, imem_addr); end
    #1;
    rst_n = 1'b1; out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h2011_0003) begin
      errors++; $display("FAIL areset_restart got v=%0b %h/%h exp 1 0/20110003", out_valid, out_pc, out_instr); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_fill();
    test_stream();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h00000000, fetch address loaded on reset.
REQ-002 Parameter DEPTH, 2, prefetch buffer entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 imem_addr  output  32  byte address presented to the instruction memory; equals the fetch PC register.
REQ-006 imem_data  input  32  instruction word returned combinationally for imem_addr in the same cycle.
REQ-007 redirect_valid  input  1  branch/jump taken; flush and restart fetch.
REQ-008 redirect_pc  input  32  restart byte address; bits [1:0] ignored.
REQ-009 out_valid  output  1  out_instr/out_pc hold a valid fetched word.
REQ-010 out_instr  output  32  instruction word at the buffer head.
REQ-011 out_pc  output  32  byte address of out_instr.
REQ-012 out_ready  input  1  consumer accepts the head entry when out_valid=1.

Function
REQ-013 Fetch PC register (fpc) SHALL drive imem_addr directly; bits [1:0] always 0.
REQ-014 Enqueue condition: redirect_valid=0 AND (count<DEPTH OR dequeue this cycle); on enqueue, {fpc, imem_data} written at tail and fpc <= fpc+4.
REQ-015 Dequeue: out_valid=1 AND out_ready=1; head advances at the clock edge.
REQ-016 out_valid = (count!=0); out_instr/out_pc are the registered head entry, never combinational from imem_data.
REQ-017 Latency: word at address A captured at the edge where imem_addr=A, visible on outputs the following cycle (1-cycle fetch-to-output).
REQ-018 Full (count=DEPTH) without dequeue: no enqueue, fpc and imem_addr hold.
REQ-019 Full with dequeue in same cycle: enqueue and dequeue both occur; count unchanged; sustained throughput 1 word/cycle.
REQ-020 Empty: out_valid=0; out_ready ignored.
REQ-021 Redirect: at the edge, count <= 0, head/tail pointers <= 0, fpc <= {redirect_pc[31:2],2'b00}; no enqueue and no dequeue that cycle, even if out_ready=1; out_valid=0 in the next cycle.
REQ-022 Back-to-back redirects: last one wins; each clears the buffer.
REQ-023 fpc wraps 32'hFFFFFFFC -> 32'h00000000 with no flag.
REQ-024 imem_data=0 (unmapped address) SHALL be enqueued as an ordinary instruction; no decoding inside this block.
REQ-025 Pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.

Reset
REQ-026 rst_n=0 asynchronously: fpc=RESET_PC, count=0, pointers=0, out_valid=0, out_instr=0, out_pc=0.
REQ-027 Reset asserted mid-stream discards all buffered words; first enqueue after release is from RESET_PC on the first rising edge with rst_n=1.
REQ-028 Buffer storage need not be reset; outputs SHALL read 0 whenever count=0.

Structure
REQ-029 Shared package holds RESET_PC default, instruction width (32) and PC increment (4) constants.
REQ-030 One sub-module natural: fetch_fifo (DEPTH-entry {pc,instr} FIFO with flush input); fpc logic stays in instr_fetch.

Verification
REQ-031 Reset then release, out_ready=1, memory word 0 = 32'h20110003 -> cycle after first edge: out_valid=1, out_pc=0, out_instr=32'h20110003; imem_addr=4.
REQ-032 out_ready=0 for 4 cycles from reset -> buffer fills with pc 0,4; imem_addr holds 32'h00000008; out_pc stays 0.
REQ-033 Full buffer, out_ready=1 -> one word per cycle, out_pc 0,4,8,C consecutively, no gaps or duplicates.
REQ-034 redirect_valid=1, redirect_pc=32'h00000023 with out_ready=1 -> next cycle out_valid=0, imem_addr=32'h00000020; following cycle out_pc=32'h20, out_instr=32'h2013000F.
REQ-035 Redirect to 32'hFFFFFFFC -> out_pc FFFFFFFC then 00000000; unmapped word delivered as out_instr=0.
REQ-036 rst_n pulsed low mid-stream with 2 words buffered -> out_valid=0 immediately (asynchronous); after release, out_pc restarts at RESET_PC.
